frame_phase_sequencer: RTL and testbench

- Owns the game's frame timing and sequences each frame's work.
- Generates the frame tick (default 60 Hz from 50 MHz) and the slow tick (every SLOW_FRAMES frames, default 5 Hz).
- Per frame, runs ERASE -> UPDATE -> DRAW with start/done handshakes to the VGA erase and draw engines, and pulses the game-logic update.
- Detects frames that arrive while the previous frame is unfinished (overrun).

---
 rtl/frame_phase_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_frame_phase_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_phase_sequencer.sv
// frame_phase_sequencer: frame timebase and per-frame ERASE -> UPDATE -> DRAW sequencer.
// Produces the frame tick (FRAME_DIV cycles) and the slow tick (every SLOW_FRAMES frames),
// runs the erase/draw handshakes and the game-logic update pulse, and flags frames that
// arrive while the previous one is still in progress (overrun, saturating missed count).
// Optional build macro FRAME_WATCHDOG_EN: per-phase timeout of WDT_CYCLES cycles that
// forces the phase to advance and sets a sticky wdt_timeout_o flag.
module frame_phase_sequencer #(
  parameter int unsigned FRAME_DIV   = 833333,
  parameter int unsigned SLOW_FRAMES = 12,
  parameter int unsigned WDT_CYCLES  = 65535
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       pause_i,
  input  logic       erase_done_i,
  input  logic       draw_done_i,
  input  logic       clear_overrun_i,
  output logic       frame_tick_o,
  output logic       slow_tick_o,
  output logic       erase_start_o,
  output logic       update_pulse_o,
  output logic       slow_update_o,
  output logic       draw_start_o,
  output logic       busy_o,
  output logic [1:0] phase_o,
  output logic       overrun_o,
  output logic [7:0] missed_count_o
`ifdef FRAME_WATCHDOG_EN
  ,
  output logic       wdt_timeout_o
`endif
);

  localparam int unsigned DIV_W  = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int unsigned SLOW_W = (SLOW_FRAMES > 1) ? $clog2(SLOW_FRAMES) : 1;
  localparam logic [DIV_W-1:0]  DIV_RELOAD = DIV_W'(FRAME_DIV - 1);
  localparam logic [SLOW_W-1:0] SLOW_LAST  = SLOW_W'(SLOW_FRAMES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ERASE  = 2'd1,
    ST_UPDATE = 2'd2,
    ST_DRAW   = 2'd3
  } state_e;

  logic [DIV_W-1:0]  div_q;
  logic              frame_tick_q;
  logic [SLOW_W-1:0] slow_cnt_q;
  logic              slow_tick_q;
  logic              slow_pend_q;
  logic              slow_pend_d;
  state_e            state_q;
  logic              erase_start_q;
  logic              update_pulse_q;
  logic              slow_update_q;
  logic              draw_start_q;
  logic              busy_q;
  logic              overrun_q;
  logic [7:0]        missed_q;
  logic              drop_evt;
  logic              wdt_fire;

  // Frame divider: free-running down-counter, tick registered on the reload edge
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      div_q        <= DIV_RELOAD;
      frame_tick_q <= 1'b0;
    end else if (div_q == '0) begin
      div_q        <= DIV_RELOAD;
      frame_tick_q <= 1'b1;
    end else begin
      div_q        <= div_q - 1'b1;
      frame_tick_q <= 1'b0;
    end
  end

  // Slow counter: advances with the frame tick, slow tick rides on the wrapping frame tick
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      slow_cnt_q  <= '0;
      slow_tick_q <= 1'b0;
    end else begin
      slow_tick_q <= 1'b0;
      if (div_q == '0) begin
        if (slow_cnt_q == SLOW_LAST) begin
          slow_cnt_q  <= '0;
          slow_tick_q <= 1'b1;
        end else begin
          slow_cnt_q  <= slow_cnt_q + 1'b1;
        end
      end
    end
  end

  // Pending slow tick: consumed while in UPDATE, but a slow tick in that cycle survives
  always_comb begin
    slow_pend_d = slow_tick_q | (slow_pend_q & (state_q != ST_UPDATE));
  end

  // Slow-pending register
  always_ff @(posedge clock_i) begin
    if (reset_i) slow_pend_q <= 1'b0;
    else         slow_pend_q <= slow_pend_d;
  end

`ifdef FRAME_WATCHDOG_EN
  localparam int unsigned WDT_W = $clog2(WDT_CYCLES + 1);
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

  logic [WDT_W-1:0] wdt_cnt_q;
  logic             wdt_timeout_q;

  // Fires on the last allowed cycle of a waiting phase if its done has not shown up
  assign wdt_fire = (wdt_cnt_q == WDT_LAST) &&
                    (((state_q == ST_ERASE) && !erase_done_i) ||
                     ((state_q == ST_DRAW)  && !draw_done_i));

  // Phase cycle counter (zero in the entry cycle of ERASE/DRAW) and sticky timeout flag
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wdt_cnt_q     <= '0;
      wdt_timeout_q <= 1'b0;
    end else begin
      if ((state_q == ST_IDLE) || (state_q == ST_UPDATE)) wdt_cnt_q <= '0;
      else                                                wdt_cnt_q <= wdt_cnt_q + 1'b1;
      if (wdt_fire)             wdt_timeout_q <= 1'b1;
      else if (clear_overrun_i) wdt_timeout_q <= 1'b0;
    end
  end

  assign wdt_timeout_o = wdt_timeout_q;
`else
  logic unused_wdt_cfg;
  assign unused_wdt_cfg = ^WDT_CYCLES;
  assign wdt_fire       = 1'b0;
`endif

  // Phase FSM with registered strobes; each strobe marks the first cycle of its phase
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q        <= ST_IDLE;
      erase_start_q  <= 1'b0;
      update_pulse_q <= 1'b0;
      slow_update_q  <= 1'b0;
      draw_start_q   <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      erase_start_q  <= 1'b0;
      update_pulse_q <= 1'b0;
      slow_update_q  <= 1'b0;
      draw_start_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (frame_tick_q && !pause_i) begin
            state_q       <= ST_ERASE;
            erase_start_q <= 1'b1;
            busy_q        <= 1'b1;
          end
        end
        ST_ERASE: begin
          if (erase_done_i || wdt_fire) begin
            state_q        <= ST_UPDATE;
            update_pulse_q <= 1'b1;
            slow_update_q  <= slow_pend_d;
          end
        end
        ST_UPDATE: begin
          state_q      <= ST_DRAW;
          draw_start_q <= 1'b1;
        end
        ST_DRAW: begin
          if (draw_done_i || wdt_fire) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // A tick that lands while a frame is still in flight is dropped and counted
  assign drop_evt = frame_tick_q && (state_q != ST_IDLE);

  // Overrun flag and saturating missed counter; a coincident drop beats the clear
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      overrun_q <= 1'b0;
      missed_q  <= 8'd0;
    end else if (clear_overrun_i) begin
      overrun_q <= drop_evt;
      missed_q  <= drop_evt ? 8'd1 : 8'd0;
    end else if (drop_evt) begin
      overrun_q <= 1'b1;
      if (missed_q != 8'hFF) missed_q <= missed_q + 8'd1;
    end
  end

  assign frame_tick_o   = frame_tick_q;
  assign slow_tick_o    = slow_tick_q;
  assign erase_start_o  = erase_start_q;
  assign update_pulse_o = update_pulse_q;
  assign slow_update_o  = slow_update_q;
  assign draw_start_o   = draw_start_q;
  assign busy_o         = busy_q;
  assign phase_o        = state_q;
  assign overrun_o      = overrun_q;
  assign missed_count_o = missed_q;

endmodule

// File: tb/tb_frame_phase_sequencer.sv
// Bench for frame_phase_sequencer: directed scenarios followed by a randomized run,
// every cycle compared against a frame-level reference model.
module tb_frame_phase_sequencer;
  localparam int FD = 16;
  localparam int SF = 3;
  localparam int WD = 8;

  logic clk = 1'b0;
  logic rst = 1'b1, pause = 1'b0, edone = 1'b0, ddone = 1'b0, clr = 1'b0;
  logic ft, st, es, up, su, ds, busy, ovr;
  logic [1:0] ph;
  logic [7:0] mc;
`ifdef FRAME_WATCHDOG_EN
  logic wdt;
`endif

  int checks = 0;
  int failures = 0;

  // reference model: cycle index since reset release plus frame progress
  int mn = 0, mph = 0, mmissed = 0, mconsumed = 0, mentry = 0;
  bit movr = 0, mes = 0, mup = 0, msu = 0, mds = 0, mwdt = 0;

  int es_cyc[$], ds_cyc[$], su_cyc[$], st_cyc[$];

  always #5 clk = ~clk;

  frame_phase_sequencer #(.FRAME_DIV(FD), .SLOW_FRAMES(SF), .WDT_CYCLES(WD)) dut (
    .clock_i(clk), .reset_i(rst), .pause_i(pause), .erase_done_i(edone),
    .draw_done_i(ddone), .clear_overrun_i(clr),
    .frame_tick_o(ft), .slow_tick_o(st), .erase_start_o(es), .update_pulse_o(up),
    .slow_update_o(su), .draw_start_o(ds), .busy_o(busy), .phase_o(ph),
    .overrun_o(ovr), .missed_count_o(mc)
`ifdef FRAME_WATCHDOG_EN
    , .wdt_timeout_o(wdt)
`endif
  );

  function automatic bit tick_at(int n);
    return (n > 0) && (n % FD == 0);
  endfunction

  function automatic bit slow_at(int n);
    return (n > 0) && (n % (FD * SF) == 0);
  endfunction

  // number of slow ticks issued up to and including cycle n
  function automatic int slow_seen(int n);
    return n / (FD * SF);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    checks++;
    assert (obs === 32'(exp)) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // advance the model across one clock edge using the inputs held during cycle mn
  task automatic model_step();
    bit tk, drop, to;
    if (rst) begin
      mn = 0; mph = 0; movr = 0; mmissed = 0; mconsumed = 0; mentry = 0;
      mes = 0; mup = 0; msu = 0; mds = 0; mwdt = 0;
      return;
    end
    tk   = tick_at(mn);
    drop = tk && (mph != 0);
    to   = 0;
`ifdef FRAME_WATCHDOG_EN
    if ((mph == 1 && !edone) || (mph == 3 && !ddone)) to = ((mn - mentry) == WD - 1);
    if (to) mwdt = 1;
    else if (clr) mwdt = 0;
`endif
    if (clr) begin
      movr = drop; mmissed = drop ? 1 : 0;
    end else if (drop) begin
      movr = 1; mmissed = (mmissed >= 255) ? 255 : mmissed + 1;
    end
    mes = 0; mup = 0; msu = 0; mds = 0;
    case (mph)
      0: if (tk && !pause) begin mph = 1; mes = 1; mentry = mn + 1; end
      1: if (edone || to) begin
           mph = 2; mup = 1;
           msu = slow_seen(mn) > mconsumed;
           mconsumed = slow_seen(mn);
         end
      2: begin mph = 3; mds = 1; mentry = mn + 1; end
      3: if (ddone || to) mph = 0;
      default: mph = 0;
    endcase
    mn++;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("frame_tick", ft, tick_at(mn));
    chk("slow_tick", st, slow_at(mn));
    chk("erase_start", es, mes);
    chk("update_pulse", up, mup);
    chk("slow_update", su, msu);
    chk("draw_start", ds, mds);
    chk("busy", busy, (mph != 0));
    chk("phase", ph, mph);
    chk("overrun", ovr, movr);
    chk("missed_count", mc, mmissed);
`ifdef FRAME_WATCHDOG_EN
    chk("wdt_timeout", wdt, mwdt);
`endif
  endtask

  initial begin
    int k;
    int mc_before;
    bit saw_es;

    // reset state
    rst = 1'b1;
    repeat (3) cyc();
    chk("rst_phase", ph, 0);
    chk("rst_missed", mc, 0);

    // A: done inputs tied high, three frames
    rst = 1'b0; edone = 1'b1; ddone = 1'b1;
    for (int i = 0; i < 60; i++) begin
      cyc();
      if (es) es_cyc.push_back(mn);
      if (ds) ds_cyc.push_back(mn);
      if (su) su_cyc.push_back(mn);
      if (st) st_cyc.push_back(mn);
    end
    chk("A_es_count", es_cyc.size(), 3);
    if (es_cyc.size() == 3) begin
      chk("A_es0", es_cyc[0], 17); chk("A_es1", es_cyc[1], 33); chk("A_es2", es_cyc[2], 49);
    end
    chk("A_ds_count", ds_cyc.size(), 3);
    if (ds_cyc.size() == 3) begin
      chk("A_ds0", ds_cyc[0], 19); chk("A_ds2", ds_cyc[2], 51);
    end
    chk("A_su_count", su_cyc.size(), 1);
    if (su_cyc.size() == 1) chk("A_su_cycle", su_cyc[0], 50);
    chk("A_st_count", st_cyc.size(), 1);
    if (st_cyc.size() == 1) chk("A_st_cycle", st_cyc[0], 48);

    // B: erase_done withheld, ticks at 32 and 48 dropped
    rst = 1'b1; cyc();
    rst = 1'b0; edone = 1'b0; ddone = 1'b1;
    repeat (56) cyc();
`ifndef FRAME_WATCHDOG_EN
    chk("B_missed", mc, 2);
    chk("B_overrun", ovr, 1);
    chk("B_phase", ph, 1);
`endif
    edone = 1'b1;
    repeat (4) cyc();
    clr = 1'b1; cyc(); clr = 1'b0;
    chk("B_clr_missed", mc, 0);
    chk("B_clr_overrun", ovr, 0);

    // C: pause across the tick at 96 (also a slow tick), next frame carries slow_update
    while (mn < 90) cyc();
    mc_before = mc;
    pause = 1'b1; saw_es = 0;
    while (mn < 100) begin cyc(); if (es) saw_es = 1; end
    pause = 1'b0;
    chk("C_no_erase_start", saw_es, 0);
    chk("C_missed_same", mc, mc_before);
    su_cyc.delete();
    while (mn < 120) begin cyc(); if (su) su_cyc.push_back(mn); end
`ifndef FRAME_WATCHDOG_EN
    chk("C_su_count", su_cyc.size(), 1);
    if (su_cyc.size() == 1) chk("C_su_cycle", su_cyc[0], 114);
`endif

    // D: reset while drawing, first tick FD cycles after release
    ddone = 1'b0;
    k = 0;
    while (mph != 3 && k < 40) begin cyc(); k++; end
    chk("D_reached_draw", ph, 3);
    rst = 1'b1; cyc();
    chk("D_rst_phase", ph, 0);
    chk("D_rst_busy", busy, 0);
    rst = 1'b0; ddone = 1'b1;
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      cyc();
      if (ft) begin k = i; break; end
    end
    chk("D_first_tick", k, FD);

    // E: draw_done held low for 300 frames, missed_count saturates
    rst = 1'b1; cyc();
    rst = 1'b0; edone = 1'b1; ddone = 1'b0;
    repeat (300 * FD) cyc();
`ifndef FRAME_WATCHDOG_EN
    chk("E_saturated", mc, 255);
`endif
    while (mn % FD != 0) cyc();
    clr = 1'b1; cyc(); clr = 1'b0;
`ifndef FRAME_WATCHDOG_EN
    chk("E_clr_with_tick_missed", mc, 1);
    chk("E_clr_with_tick_overrun", ovr, 1);
`endif
    ddone = 1'b1;
    repeat (8) cyc();

    // F: randomized inputs against the model
    for (int i = 0; i < 4000; i++) begin
      rst   = ($urandom_range(0, 499) == 0);
      pause = ($urandom_range(0, 4) == 0);
      edone = ($urandom_range(0, 3) == 0);
      ddone = ($urandom_range(0, 3) == 0);
      clr   = ($urandom_range(0, 49) == 0);
      cyc();
    end
    rst = 1'b0; pause = 1'b0; clr = 1'b0;

`ifdef FRAME_WATCHDOG_EN
    // G: erase_done never arrives, watchdog advances the frame
    rst = 1'b1; cyc();
    rst = 1'b0; edone = 1'b0; ddone = 1'b0;
    k = 0;
    while (!es && k < 40) begin cyc(); k++; end
    chk("G_erase_started", es, 1);
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      cyc();
      if (up) begin k = i; break; end
    end
    chk("G_update_delay", k, WD);
    chk("G_wdt_timeout", wdt, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
